spine_uplink_buffer: RTL and testbench
======================================

// Module: spine_uplink_buffer
// PURPOSE
//   Elastic buffer on a leaf router's spine output (spineNN_out_data/valid) feeding the spine switch.
//   The router's spine outputs carry no ready, so this block absorbs bursts, applies spine backpressure
//   and drops/counts flits on overflow. One instance per spine port.
//   It also presents the 6-bit destination address field (flit[15:10]) next to each flit for spine routing.
// PARAMETERS
//   DWIDTH      16  flit width; destination field is flit[DWIDTH-1:DWIDTH-6]
//   DEPTH       8   FIFO entries; power of two, >=2
//   AFULL_LVL   6   occupancy at/above which afull asserts; 1..DEPTH
//   DROP_CNT_W  8   width of saturating drop counter
// PORTS
//   ACLK             in   1                 clock, rising edge
//   ARESETn          in   1                 async active-low reset
//   leaf_in_data     in   DWIDTH            flit from router spine output
//   leaf_in_valid    in   1                 flit valid; no ready returned
//   spine_out_data   out  DWIDTH            head-of-FIFO flit
//   spine_out_valid  out  1                 FIFO non-empty
//   spine_out_ready  in   1                 spine switch accepts flit
//   spine_dest_addr  out  6                 spine_out_data[DWIDTH-1:DWIDTH-6]
//   occupancy        out  $clog2(DEPTH)+1   entries held, 0..DEPTH
//   afull            out  1                 occupancy >= AFULL_LVL
//   overflow         out  1                 sticky: at least one flit dropped
//   drop_count       out  DROP_CNT_W        flits dropped, saturating
//   clear_stats      in   1                 sync pulse: clears overflow and drop_count
// BEHAVIOUR
//   Reset (ARESETn low, async): wr/rd pointers, occupancy, overflow, drop_count -> 0; spine_out_valid=0,
//     afull=0, spine_out_data/spine_dest_addr=0. Storage array needs no reset. No flit survives reset.
//   pop  = spine_out_valid & spine_out_ready.
//   push = leaf_in_valid & (occupancy<DEPTH | pop); the full-with-simultaneous-pop case accepts the flit.
//   drop = leaf_in_valid & ~push, i.e. FIFO full and no pop in the same cycle.
//   Latency: a flit pushed at edge N is on spine_out_data at N+1 if the FIFO was empty (one-cycle, no bypass).
//   Head output: spine_out_data = mem[rd_ptr] when valid, else 0; spine_dest_addr follows it combinationally.
//   Handshake: while spine_out_valid=1 and ready=0, spine_out_data stays stable; valid never drops without a pop.
//   Order: strict FIFO; pointers wrap modulo DEPTH; occupancy +1 push-only, -1 pop-only, unchanged for both/neither.
//   Push+pop on an empty FIFO: nothing pops because valid=0; the push lands normally.
//   Stats: on drop, overflow<=1 and drop_count increments, holding at 2^DROP_CNT_W-1.
//     clear_stats has priority: drop and clear in the same cycle -> overflow=0, drop_count=0.
//   afull, occupancy: registered-state derived, updated the cycle after push/pop.
//   No FSM beyond FIFO state: EMPTY (occ=0), PARTIAL, FULL (occ=DEPTH); transitions come only from push/pop above.
// TESTING
//   1 Single flit 16'hA5C3 with ready=1 -> valid at next cycle, data A5C3, dest_addr 6'h29, occupancy back to 0.
//   2 8 back-to-back flits 0x0001..0x0008, ready=0 -> occupancy=8, afull from 6th, data held 0x0001;
//     then ready=1 -> 0x0001..0x0008 in order over 8 cycles.
//   3 FIFO full, ready=0, 3 more valid flits -> drop_count=3, overflow=1, contents unchanged;
//     clear_stats pulse -> both 0.
//   4 FIFO full, ready=1 and new flit 0x00FF same cycle -> no drop, occupancy stays 8, 0x00FF emerges last.
//   5 Continuous stream, ready=1 always -> throughput 1 flit/cycle, occupancy 1 steady, drop_count 0.
//   6 Assert ARESETn low mid-burst with occupancy 5 -> valid=0, occupancy=0 immediately (async);
//     after release, first new flit emerges next cycle with no stale data.

Source files
------------

// File: rtl/spine_uplink_buffer.sv
// spine_uplink_buffer
// Elastic FIFO between a leaf router's spine output (which has no ready)
// and the spine switch. Absorbs bursts, honours spine backpressure, drops
// and counts flits on overflow, and exposes the destination field of the
// head flit for spine routing.
module spine_uplink_buffer #(
    parameter int DWIDTH     = 16,
    parameter int DEPTH      = 8,
    parameter int AFULL_LVL  = 6,
    parameter int DROP_CNT_W = 8
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [DWIDTH-1:0]        leaf_in_data,
    input  logic                     leaf_in_valid,
    output logic [DWIDTH-1:0]        spine_out_data,
    output logic                     spine_out_valid,
    input  logic                     spine_out_ready,
    output logic [5:0]               spine_dest_addr,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     afull,
    output logic                     overflow,
    output logic [DROP_CNT_W-1:0]    drop_count,
    input  logic                     clear_stats
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [DWIDTH-1:0]     mem_q [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]         occ_q, occ_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic                  not_empty;
    logic                  push;
    logic                  pop;
    logic                  drop;

    // Handshake decode: a full FIFO still accepts a flit when the head pops
    // in the same cycle; anything else arriving while full is dropped.
    always_comb begin
        not_empty = (occ_q != '0);
        pop       = not_empty & spine_out_ready;
        push      = leaf_in_valid & ((occ_q < OW'(DEPTH)) | pop);
        drop      = leaf_in_valid & ~push;
    end

    // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Drop statistics; a clear wins over a drop in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_stats) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
            end
        end
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Flit storage; no reset needed since occupancy gates every read.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= leaf_in_data;
        end
    end

    // Output view: head flit masked to zero while empty, status from state.
    always_comb begin
        spine_out_valid = not_empty;
        spine_out_data  = not_empty ? mem_q[rd_ptr_q] : '0;
        spine_dest_addr = spine_out_data[DWIDTH-1 -: 6];
        occupancy       = occ_q;
        afull           = (occ_q >= OW'(AFULL_LVL));
        overflow        = overflow_q;
        drop_count      = drop_cnt_q;
    end

endmodule

// File: tb/tb_spine_uplink_buffer.sv
// Self-checking bench for spine_uplink_buffer: constant vector table,
// directed corner sequences, and randomized traffic against a queue model.
module tb_spine_uplink_buffer;

    localparam int DW    = 16;
    localparam int DEP   = 8;
    localparam int AFL   = 6;
    localparam int DCW   = 8;

    logic           ACLK = 1'b0;
    logic           ARESETn;
    logic [DW-1:0]  leaf_in_data;
    logic           leaf_in_valid;
    logic [DW-1:0]  spine_out_data;
    logic           spine_out_valid;
    logic           spine_out_ready;
    logic [5:0]     spine_dest_addr;
    logic [3:0]     occupancy;
    logic           afull;
    logic           overflow;
    logic [DCW-1:0] drop_count;
    logic           clear_stats;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state
    logic [DW-1:0]  mq[$];
    logic           m_ovf;
    int unsigned    m_drops;

    spine_uplink_buffer #(
        .DWIDTH    (DW),
        .DEPTH     (DEP),
        .AFULL_LVL (AFL),
        .DROP_CNT_W(DCW)
    ) dut (
        .ACLK           (ACLK),
        .ARESETn        (ARESETn),
        .leaf_in_data   (leaf_in_data),
        .leaf_in_valid  (leaf_in_valid),
        .spine_out_data (spine_out_data),
        .spine_out_valid(spine_out_valid),
        .spine_out_ready(spine_out_ready),
        .spine_dest_addr(spine_dest_addr),
        .occupancy      (occupancy),
        .afull          (afull),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_stats    (clear_stats)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic compare_model(input string tag);
        logic [DW-1:0] head;
        head = '0;
        if (mq.size() > 0) head = mq[0];
        chk({tag, ".valid"}, 32'(spine_out_valid), 32'(mq.size() > 0));
        chk({tag, ".data"},  32'(spine_out_data), 32'(head));
        chk({tag, ".dest"},  32'(spine_dest_addr), 32'(head[15:10]));
        chk({tag, ".occ"},   32'(occupancy), 32'(mq.size()));
        chk({tag, ".afull"}, 32'(afull), 32'(mq.size() >= AFL));
        chk({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
        chk({tag, ".drops"}, 32'(drop_count), m_drops);
    endtask

    // One clock: drive inputs, advance model, sample 1 ns after the edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r,
                       input logic c, input string tag);
        bit m_pop, m_push, m_drop;
        leaf_in_valid   = v;
        leaf_in_data    = d;
        spine_out_ready = r;
        clear_stats     = c;
        m_pop  = (mq.size() > 0) && r;
        m_push = v && ((mq.size() < DEP) || m_pop);
        m_drop = v && !m_push;
        @(posedge ACLK);
        #1;
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back(d);
        if (c) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end else if (m_drop) begin
            m_ovf = 1'b1;
            if (m_drops != 255) m_drops++;
        end
        compare_model(tag);
    endtask

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          r;
        logic          c;
        logic          ev;
        logic [DW-1:0] ed;
        int unsigned   eocc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        ARESETn         = 1'b0;
        leaf_in_valid   = 1'b0;
        leaf_in_data    = '0;
        spine_out_ready = 1'b0;
        clear_stats     = 1'b0;
        model_reset();

        tbl[0] = '{1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b1, 16'hA5C3, 1};
        tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 0};
        tbl[2] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h1234, 1};
        tbl[3] = '{1'b1, 16'h5678, 1'b0, 1'b0, 1'b1, 16'h1234, 2};
        tbl[4] = '{1'b1, 16'h9ABC, 1'b1, 1'b0, 1'b1, 16'h5678, 2};
        tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h9ABC, 1};
        tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 0};
        tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 0};

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        compare_model("reset");
        ARESETn = 1'b1;

        // Table-driven vectors (row 0 is the single 16'hA5C3 flit)
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.valid_k", i), 32'(spine_out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d.data_k", i), 32'(spine_out_data), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d.occ_k", i), 32'(occupancy), tbl[i].eocc);
            if (i == 0) chk("t1.dest_29", 32'(spine_dest_addr), 32'h29);
        end

        // Fill with 1..8 under backpressure, then drain in order
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 16'(i), 1'b0, 1'b0, "t2.fill");
            chk("t2.occ_k", 32'(occupancy), 32'(i));
            chk("t2.afull_k", 32'(afull), 32'(i >= 6));
            chk("t2.head_held", 32'(spine_out_data), 32'h1);
        end
        for (int i = 1; i <= 8; i++) begin
            chk("t2.drain_head", 32'(spine_out_data), 32'(i));
            cyc(1'b0, '0, 1'b1, 1'b0, "t2.drain");
        end
        chk("t2.empty", 32'(spine_out_valid), 32'h0);

        // Overflow drops while full, then clear
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h10 + i), 1'b0, 1'b0, "t3.fill");
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'hDEAD, 1'b0, 1'b0, "t3.drop");
        chk("t3.drops3", 32'(drop_count), 32'd3);
        chk("t3.ovf", 32'(overflow), 32'h1);
        chk("t3.head", 32'(spine_out_data), 32'h10);
        cyc(1'b0, '0, 1'b0, 1'b1, "t3.clear");
        chk("t3.clr_drops", 32'(drop_count), 32'h0);
        chk("t3.clr_ovf", 32'(overflow), 32'h0);
        cyc(1'b1, 16'hBAD0, 1'b0, 1'b1, "t3.clr_prio");
        chk("t3.prio_drops", 32'(drop_count), 32'h0);
        chk("t3.prio_ovf", 32'(overflow), 32'h0);

        // Full with simultaneous pop and push: flit accepted, lands last
        cyc(1'b1, 16'h00FF, 1'b1, 1'b0, "t4.swap");
        chk("t4.occ8", 32'(occupancy), 32'd8);
        chk("t4.nodrop", 32'(drop_count), 32'h0);
        for (int i = 0; i < 8; i++) begin
            chk("t4.order", 32'(spine_out_data), (i == 7) ? 32'h00FF : 32'(16'h11 + i));
            cyc(1'b0, '0, 1'b1, 1'b0, "t4.drain");
        end

        // Drop counter saturation
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, "sat.fill");
        for (int i = 0; i < 260; i++) cyc(1'b1, 16'hEEEE, 1'b0, 1'b0, "sat.drop");
        chk("sat.255", 32'(drop_count), 32'd255);
        cyc(1'b0, '0, 1'b0, 1'b1, "sat.clear");
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0, "sat.drain");

        // Continuous stream at one flit per cycle
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b1, 16'(16'h100 + i), 1'b1, 1'b0, "t5.stream");
            chk("t5.occ1", 32'(occupancy), 32'h1);
            chk("t5.data", 32'(spine_out_data), 32'(16'h100 + i));
        end
        cyc(1'b0, '0, 1'b1, 1'b0, "t5.end");
        chk("t5.drops0", 32'(drop_count), 32'h0);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h200 + i), 1'b0, 1'b0, "t6.fill");
        chk("t6.occ5", 32'(occupancy), 32'd5);
        leaf_in_valid = 1'b0;
        #2 ARESETn = 1'b0;
        #1;
        chk("t6.async_valid", 32'(spine_out_valid), 32'h0);
        chk("t6.async_occ", 32'(occupancy), 32'h0);
        model_reset();
        @(posedge ACLK);
        #1 ARESETn = 1'b1;
        compare_model("t6.held");
        cyc(1'b1, 16'hBEEF, 1'b0, 1'b0, "t6.first");
        chk("t6.fresh", 32'(spine_out_data), 32'hBEEF);
        chk("t6.fresh_occ", 32'(occupancy), 32'h1);
        cyc(1'b0, '0, 1'b1, 1'b0, "t6.drain");

        // Randomized traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            logic rv, rr, rc;
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 2) == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            if (i % 500 < 100) rr = ($urandom_range(0, 5) == 0);
            rc = ($urandom_range(0, 63) == 0);
            cyc(rv, 16'($urandom), rr, rc, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
